// File: rtl/ascon_pack.sv
// ASCON-128 encryption sequencer: shared state/opcode types,
// round bounds and the ASCON-128 IV.
package ascon_pack;

   localparam logic [3:0]  ROUND_P12_START = 4'd0;
   localparam logic [3:0]  ROUND_P6_START  = 4'd6;
   localparam logic [3:0]  ROUND_LAST      = 4'd11;
   localparam logic [63:0] ASCON_128_IV    = 64'h80400c0600000000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_AD_WAIT,
      S_AD_PERM,
      S_PT_WAIT,
      S_PT_PERM,
      S_FINAL,
      S_DONE
   } seq_state_t;

   typedef enum logic [1:0] {
      RC_HOLD,
      RC_LOAD_P12,
      RC_LOAD_P6,
      RC_INC
   } rc_op_t;

   typedef enum logic [1:0] {
      BC_HOLD,
      BC_CLEAR,
      BC_INC
   } bc_op_t;

   // The last plaintext block is absorbed at round 0 of the
   // finalisation p12; every other block at round 6 of a p6.
   function automatic rc_op_t pt_entry_op(input logic [3:0] blk,
                                          input logic [3:0] last);
      return (blk == last) ? RC_LOAD_P12 : RC_LOAD_P6;
   endfunction

endpackage

// File: rtl/ascon_enc_sequencer_if.sv
// Control bundle between the ASCON wrapper (master) and the
// encryption sequencer (slave): start/data handshake + datapath strobes.
interface ascon_enc_sequencer_if;

   logic       start_i;
   logic       data_valid_i;
   logic       data_ready_o;
   logic [3:0] round_o;
   logic       sel_init_o;
   logic       en_state_o;
   logic       xor_data_b_o;
   logic       xor_key_b_o;
   logic       xor_key_e_o;
   logic       xor_lsb_e_o;
   logic       en_cipher_o;
   logic       en_tag_o;
   logic       cipher_valid_o;
   logic [3:0] block_o;
   logic       end_o;

   modport master (
      output start_i, data_valid_i,
      input  data_ready_o, round_o, sel_init_o, en_state_o,
      input  xor_data_b_o, xor_key_b_o, xor_key_e_o, xor_lsb_e_o,
      input  en_cipher_o, en_tag_o, cipher_valid_o, block_o, end_o
   );

   modport slave (
      input  start_i, data_valid_i,
      output data_ready_o, round_o, sel_init_o, en_state_o,
      output xor_data_b_o, xor_key_b_o, xor_key_e_o, xor_lsb_e_o,
      output en_cipher_o, en_tag_o, cipher_valid_o, block_o, end_o
   );

endinterface

// File: rtl/ascon_round_counter.sv
// 4-bit permutation round counter: hold / load 0 / load 6 / increment.
// Ports: clock_i, resetb_i (async low), op_i, round_o.
module ascon_round_counter
   import ascon_pack::*;
(
   input  logic       clock_i,
   input  logic       resetb_i,
   input  rc_op_t     op_i,
   output logic [3:0] round_o
);

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         round_o <= ROUND_P12_START;
      end else begin
         unique case (op_i)
            RC_HOLD:     round_o <= round_o;
            RC_LOAD_P12: round_o <= ROUND_P12_START;
            RC_LOAD_P6:  round_o <= ROUND_P6_START;
            RC_INC:      round_o <= round_o + 4'd1;
            default:     round_o <= round_o;
         endcase
      end
   end

endmodule

// File: rtl/ascon_enc_sequencer.sv
// ASCON-128 encryption control FSM: init p12, AD p6 (ASCON_AD_EN),
// PT p6, final p12. Ports: clock_i, resetb_i, bus (slave modport).
module ascon_enc_sequencer
   import ascon_pack::*;
#(
   parameter int NB_AD_BLOCKS = 1,
   parameter int NB_PT_BLOCKS = 4
) (
   input  logic                  clock_i,
   input  logic                  resetb_i,
   ascon_enc_sequencer_if.slave  bus
);

   localparam logic [3:0] AD_LAST = 4'(NB_AD_BLOCKS - 1);
   localparam logic [3:0] PT_LAST = 4'(NB_PT_BLOCKS - 1);

   seq_state_t state_q, state_d;
   rc_op_t     rc_op;
   bc_op_t     bc_op;
   logic [3:0] round_q;
   logic [3:0] blk_q;
   logic [3:0] blk_next;
   logic       blk_last;
   logic       round_last;
   logic       cipher_valid_q;

   logic rdy, sel, en, xdb, xkb, xke, xle, ec, et, fin;

   ascon_round_counter u_round (
      .clock_i  (clock_i),
      .resetb_i (resetb_i),
      .op_i     (rc_op),
      .round_o  (round_q)
   );

   assign blk_next   = blk_q + 4'd1;
   assign round_last = (round_q == ROUND_LAST);
   assign blk_last   = (state_q == S_AD_WAIT || state_q == S_AD_PERM)
                     ? (blk_q == AD_LAST) : (blk_q == PT_LAST);

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state_q        <= S_IDLE;
         blk_q          <= '0;
         cipher_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cipher_valid_q <= ec;
         unique case (bc_op)
            BC_HOLD:  blk_q <= blk_q;
            BC_CLEAR: blk_q <= '0;
            BC_INC:   blk_q <= blk_next;
            default:  blk_q <= blk_q;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      rc_op   = RC_HOLD;
      bc_op   = BC_HOLD;
      rdy     = 1'b0;
      sel     = 1'b0;
      en      = 1'b0;
      xdb     = 1'b0;
      xkb     = 1'b0;
      xke     = 1'b0;
      xle     = 1'b0;
      ec      = 1'b0;
      et      = 1'b0;
      fin     = 1'b0;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            fin = (state_q == S_DONE);
            if (bus.start_i) begin
               state_d = S_INIT;
               rc_op   = RC_LOAD_P12;
               bc_op   = BC_CLEAR;
            end
         end
         S_INIT: begin
            en    = 1'b1;
            sel   = (round_q == ROUND_P12_START);
            rc_op = RC_INC;
            if (round_last) begin
               xke   = 1'b1;
               bc_op = BC_CLEAR;
`ifdef ASCON_AD_EN
               state_d = S_AD_WAIT;
               rc_op   = RC_LOAD_P6;
`else
               // No AD: the empty-AD domain separation lands here.
               xle     = 1'b1;
               state_d = S_PT_WAIT;
               rc_op   = pt_entry_op(4'd0, PT_LAST);
`endif
            end
         end
         S_AD_WAIT: begin
            rdy = 1'b1;
            if (bus.data_valid_i) begin
               en      = 1'b1;
               xdb     = 1'b1;
               rc_op   = RC_INC;
               state_d = S_AD_PERM;
            end
         end
         S_AD_PERM: begin
            en    = 1'b1;
            rc_op = RC_INC;
            if (round_last) begin
               if (blk_last) begin
                  xle     = 1'b1;
                  bc_op   = BC_CLEAR;
                  state_d = S_PT_WAIT;
                  rc_op   = pt_entry_op(4'd0, PT_LAST);
               end else begin
                  bc_op   = BC_INC;
                  state_d = S_AD_WAIT;
                  rc_op   = RC_LOAD_P6;
               end
            end
         end
         S_PT_WAIT: begin
            rdy = 1'b1;
            xkb = blk_last;
            if (bus.data_valid_i) begin
               en    = 1'b1;
               xdb   = 1'b1;
               ec    = 1'b1;
               rc_op = RC_INC;
               if (blk_last) begin
                  bc_op   = BC_CLEAR;
                  state_d = S_FINAL;
               end else begin
                  state_d = S_PT_PERM;
               end
            end
         end
         S_PT_PERM: begin
            en    = 1'b1;
            rc_op = RC_INC;
            if (round_last) begin
               bc_op   = BC_INC;
               state_d = S_PT_WAIT;
               rc_op   = pt_entry_op(blk_next, PT_LAST);
            end
         end
         S_FINAL: begin
            en    = 1'b1;
            rc_op = RC_INC;
            if (round_last) begin
               xke     = 1'b1;
               et      = 1'b1;
               state_d = S_DONE;
               rc_op   = RC_LOAD_P12;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.data_ready_o   = rdy;
   assign bus.round_o        = round_q;
   assign bus.sel_init_o     = sel;
   assign bus.en_state_o     = en;
   assign bus.xor_data_b_o   = xdb;
   assign bus.xor_key_b_o    = xkb;
   assign bus.xor_key_e_o    = xke;
   assign bus.xor_lsb_e_o    = xle;
   assign bus.en_cipher_o    = ec;
   assign bus.en_tag_o       = et;
   assign bus.cipher_valid_o = cipher_valid_q;
   assign bus.block_o        = blk_q;
   assign bus.end_o          = fin;

endmodule

// File: tb/tb_ascon_enc_sequencer.sv
// Directed bench for ascon_enc_sequencer: cycle-indexed snapshots
// compared against a hand-computed vector table plus corner sequences.
module tb_ascon_enc_sequencer;

`ifdef ASCON_AD_EN
   localparam int A     = 6;
   localparam int XLE12 = 0;
`else
   localparam int A     = 0;
   localparam int XLE12 = 1;
`endif

   typedef struct packed {
      logic       rdy;
      logic [3:0] rnd;
      logic       sel;
      logic       en;
      logic       xdb;
      logic       xkb;
      logic       xke;
      logic       xle;
      logic       ec;
      logic       et;
      logic       cv;
      logic [3:0] blk;
      logic       fin;
   } out_t;

   typedef struct {
      string name;
      int    t;
      out_t  exp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   out_t snap [0:63];
   vec_t vec [$];

   ascon_enc_sequencer_if bus ();

   ascon_enc_sequencer #(
      .NB_AD_BLOCKS (1),
      .NB_PT_BLOCKS (4)
   ) dut (
      .clock_i  (clk),
      .resetb_i (rst_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   function automatic out_t o(int rdy, int rnd, int sel, int en,
                              int xdb, int xkb, int xke, int xle,
                              int ec, int et, int cv, int blk, int fin);
      out_t r;
      r.rdy = rdy[0];
      r.rnd = 4'(rnd);
      r.sel = sel[0];
      r.en  = en[0];
      r.xdb = xdb[0];
      r.xkb = xkb[0];
      r.xke = xke[0];
      r.xle = xle[0];
      r.ec  = ec[0];
      r.et  = et[0];
      r.cv  = cv[0];
      r.blk = 4'(blk);
      r.fin = fin[0];
      return r;
   endfunction

   function automatic out_t cur();
      return o(32'(bus.data_ready_o), 32'(bus.round_o),
               32'(bus.sel_init_o), 32'(bus.en_state_o),
               32'(bus.xor_data_b_o), 32'(bus.xor_key_b_o),
               32'(bus.xor_key_e_o), 32'(bus.xor_lsb_e_o),
               32'(bus.en_cipher_o), 32'(bus.en_tag_o),
               32'(bus.cipher_valid_o), 32'(bus.block_o),
               32'(bus.end_o));
   endfunction

   task automatic check(input string name, input out_t got, input out_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic add(input string n, input int t, input out_t e);
      vec_t v;
      v.name = n;
      v.t    = t;
      v.exp  = e;
      vec.push_back(v);
   endtask

   // Entered just after a rising edge; t=0 is the start_i cycle.
   task automatic run(input int ncyc, input int stall_at,
                      input int stall_len, input bit pulses);
      for (int t = 0; t <= ncyc; t++) begin
         bus.start_i      = (t == 0) || (pulses && (t == 5 || t == 20));
         bus.data_valid_i = !(t >= stall_at && t < stall_at + stall_len);
         @(negedge clk);
         snap[t] = cur();
         @(posedge clk);
         #1;
      end
      bus.start_i      = 1'b0;
      bus.data_valid_i = 1'b1;
   endtask

   task automatic check_table(input string tag, input int lo, input int hi);
      foreach (vec[i]) begin
         if (vec[i].t >= lo && vec[i].t <= hi)
            check({tag, "/", vec[i].name}, snap[vec[i].t], vec[i].exp);
      end
   endtask

   out_t zero;
   out_t done_o;
   out_t wait_o;

   initial begin
      clk    = 1'b0;
      rst_n  = 1'b1;
      errors = 0;
      checks = 0;
      bus.start_i      = 1'b0;
      bus.data_valid_i = 1'b1;
      zero   = o(0,0,0,0,0,0,0,0,0,0,0,0,0);
      done_o = o(0,0,0,0,0,0,0,0,0,0,0,0,1);
      wait_o = o(1,6,0,0,0,0,0,0,0,0,0,0,0);

      add("idle_t0",    0,      zero);
      add("init_r0",    1,      o(0,0,1,1,0,0,0,0,0,0,0,0,0));
      add("init_r4",    5,      o(0,4,0,1,0,0,0,0,0,0,0,0,0));
      add("init_r11",   12,     o(0,11,0,1,0,0,1,XLE12,0,0,0,0,0));
`ifdef ASCON_AD_EN
      add("ad_hs",      13,     o(1,6,0,1,1,0,0,0,0,0,0,0,0));
      add("ad_r7",      14,     o(0,7,0,1,0,0,0,0,0,0,0,0,0));
      add("ad_r11",     18,     o(0,11,0,1,0,0,0,1,0,0,0,0,0));
`endif
      add("pt0_hs",     13 + A, o(1,6,0,1,1,0,0,0,1,0,0,0,0));
      add("pt0_r7",     14 + A, o(0,7,0,1,0,0,0,0,0,0,1,0,0));
      add("pt0_r11",    18 + A, o(0,11,0,1,0,0,0,0,0,0,0,0,0));
      add("pt1_hs",     19 + A, o(1,6,0,1,1,0,0,0,1,0,0,1,0));
      add("pt1_cv",     20 + A, o(0,7,0,1,0,0,0,0,0,0,1,1,0));
      add("pt2_hs",     25 + A, o(1,6,0,1,1,0,0,0,1,0,0,2,0));
      add("pt3_hs",     31 + A, o(1,0,0,1,1,1,0,0,1,0,0,3,0));
      add("fin_r1",     32 + A, o(0,1,0,1,0,0,0,0,0,0,1,0,0));
      add("fin_r11",    42 + A, o(0,11,0,1,0,0,1,0,0,1,0,0,0));
      add("done",       43 + A, done_o);
      add("done_hold",  46 + A, done_o);

      #1 rst_n = 1'b0;
      #1 check("reset_async", cur(), zero);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run(46 + A, -10, 0, 1'b0);
      check_table("full", 0, 99);

      run(49 + A, 13 + A, 3, 1'b0);
      check("done_start",   snap[0],          done_o);
      check("done_restart", snap[1],          o(0,0,1,1,0,0,0,0,0,0,0,0,0));
      check("stall_c0",     snap[13 + A],     wait_o);
      check("stall_c2",     snap[15 + A],     wait_o);
      check("stall_hs",     snap[16 + A],     o(1,6,0,1,1,0,0,0,1,0,0,0,0));
      check("stall_perm",   snap[17 + A],     o(0,7,0,1,0,0,0,0,0,0,1,0,0));
      check("stall_tag",    snap[45 + A],     o(0,11,0,1,0,0,1,0,0,1,0,0,0));
      check("stall_end",    snap[46 + A],     done_o);

      run(39, -10, 0, 1'b1);
      check_table("pulses", 1, 39);
      #2 rst_n = 1'b0;
      #1 check("reset_mid", cur(), zero);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run(46 + A, -10, 0, 1'b0);
      check_table("rerun", 0, 99);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
